// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame geometry.
// Used by both the receiver and transmitter sides of the echo path.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t IDLE      = 3'd0;
  localparam uart_state_t START     = 3'd1;
  localparam uart_state_t DATA      = 3'd2;
  localparam uart_state_t STOP      = 3'd3;
  localparam uart_state_t WAIT_HIGH = 3'd4;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  // start + 8 data + 1 stop
  localparam int FRAME_BITS_8N1 = 10;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for async inputs, resets to all-ones (idle-high lines).
// Latency: 2 clk; no backpressure.
module uart_rx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver: byte out with a one-clk valid, or a frame_err pulse.
// Latency: valid one clk after the stop-bit sample; no backpressure (consumer must take the pulse).
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx_tick,
  input  logic                 enabled,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_t          state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [BW-1:0]        bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt, frame_err_nxt;

  uart_rx_sync #(.WIDTH(1)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (rx),
    .q      (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift     <= shift_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bit_idx_nxt   = bit_idx;
    shift_nxt     = shift;
    data_nxt      = data;
    valid_nxt     = 1'b0;
    frame_err_nxt = 1'b0;
    // Disable aborts immediately, independent of the tick.
    if (!enabled) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      bit_idx_nxt = '0;
    end else if (rx_tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = START;
            cnt_nxt   = '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt_nxt     = '0;
            bit_idx_nxt = '0;
            state_nxt   = rx_s ? IDLE : DATA;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
            if (bit_idx == IDX_LAST) begin
              state_nxt   = STOP;
              bit_idx_nxt = '0;
            end else begin
              bit_idx_nxt = bit_idx + 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            if (rx_s) begin
              data_nxt  = shift;
              valid_nxt = 1'b1;
              state_nxt = IDLE;
            end else begin
              frame_err_nxt = 1'b1;
              state_nxt     = WAIT_HIGH;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: directed frames queue expected pulses, a forked monitor pops them.
module tb_uart_rx;
  import uart_pkg::*;

  typedef struct packed {
    logic       is_err;
    logic [7:0] dat;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_tick = 1'b1;
  logic       enabled = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_rx dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx_tick   (rx_tick),
    .enabled   (enabled),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back({1'b0, b});
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives the first n clocks of a frame, one bit per OVERSAMPLE clocks, from a negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int n);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < n; i++) begin
      rx = f[i / OVERSAMPLE_DEF];
      @(negedge clk);
    end
  endtask

  initial begin
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (valid || frame_err) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_pulse", {30'd0, valid, frame_err}, 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("pulse_kind", {30'd0, valid, frame_err}, e.is_err ? 32'd1 : 32'd2);
              chk("pulse_data", {24'd0, data}, {24'd0, e.dat});
              if (!e.is_err) chk("busy_at_valid", {31'd0, busy}, 32'd0);
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    resetn = 1'b1;
    idle(20);

    // 0xA5: start driven at N0, T0 = edge 3, stop sample edge 155, valid seen at N155
    expect_byte(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, 160);
      begin
        repeat (154) @(negedge clk);
        chk("valid_before_stop", {31'd0, valid}, 32'd0);
        @(negedge clk);
        chk("valid_at_stop_plus1", {31'd0, valid}, 32'd1);
      end
    join
    idle(20);

    // 4-clk glitch: START from edge 3 to edge 11 -> busy for 8 clks
    begin : glitch
      int bc;
      bc = 0;
      fork
        begin
          rx = 1'b0;
          repeat (4) @(negedge clk);
          rx = 1'b1;
          repeat (20) @(negedge clk);
        end
        begin
          repeat (24) begin
            @(negedge clk);
            if (busy) bc++;
          end
        end
      join
      chk("glitch_busy_clks", bc, 32'd8);
    end
    expect_byte(8'h5A);
    send_frame(8'h5A, 1'b1, 160);
    idle(20);

    // Broken stop bit, line held low, then recovery
    exp_q.push_back({1'b1, 8'h5A});
    send_frame(8'h3C, 1'b0, 160);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    chk("wait_high_busy", {31'd0, busy}, 32'd1);
    repeat (20) @(negedge clk);
    idle(20);
    expect_byte(8'h81);
    send_frame(8'h81, 1'b1, 160);
    idle(20);

    // Back-to-back with a single stop bit
    expect_byte(8'h00);
    expect_byte(8'hFF);
    send_frame(8'h00, 1'b1, 160);
    send_frame(8'hFF, 1'b1, 160);
    idle(20);

    // Reset for one clk in the middle of data bit 3
    send_frame(8'hC3, 1'b1, 16 + 48 + 8);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    rx = 1'b1;
    chk("midrst_data", {24'd0, data}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    idle(30);
    expect_byte(8'h42);
    send_frame(8'h42, 1'b1, 160);
    idle(20);

    // Disable during data bit 5, then a whole frame while disabled
    send_frame(8'h66, 1'b1, 104);
    chk("pre_disable_busy", {31'd0, busy}, 32'd1);
    enabled = 1'b0;
    @(negedge clk);
    chk("disable_abort_busy", {31'd0, busy}, 32'd0);
    idle(80);
    send_frame(8'h99, 1'b1, 160);
    idle(20);
    chk("disabled_busy", {31'd0, busy}, 32'd0);
    enabled = 1'b1;
    idle(20);
    expect_byte(8'h99);
    send_frame(8'h99, 1'b1, 160);
    idle(20);

    // Loopback sweep of every byte value
    for (int i = 0; i < 256; i++) begin
      expect_byte(8'(i));
      send_frame(8'(i), 1'b1, 160);
    end
    idle(200);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver, 8N1, LSB first. Counterpart of the team's `uart_tx` in the uart_echo design.
- Synchronises the RX pin and detects and validates the start bit by oversampling. Samples each data bit mid-bit and checks the stop bit.
- Presents each received byte with a one-clk valid pulse, or flags a framing error.
- Feeds the echo path: the received byte drives `uart_tx.in`, and `valid` drives `uart_tx.start`.

Parameters:
- OVERSAMPLE, 16, rx_tick pulses per bit period; must be even and ≥4.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  domain clock
- resetn  input  1  synchronous active-low reset
- rx_tick  input  1  one-clk enable pulse at OVERSAMPLE×baud
- enabled  input  1  receiver enable
- rx  input  1  asynchronous RX pin, idle high
- data  output  DATA_BITS  last good byte; holds until next good byte
- valid  output  1  one-clk pulse: data updated
- frame_err  output  1  one-clk pulse: stop bit sampled low
- busy  output  1  high while a frame is in progress (any state except IDLE)

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE, cnt=0, bit_idx=0, shift=0, data=0.
  - valid=0, frame_err=0, busy=0.
  - Synchroniser flops set to 1.
  - Reset wins over every other event, including mid-frame; a partial frame is discarded with no pulse.
- Synchroniser: 2-FF on rx, giving rx_s. This adds 2 clk of latency; all sampling uses rx_s.
- State and counter updates occur only on clk edges where rx_tick=1. The exception is valid and frame_err, which default to 0 every clk, so each pulse lasts exactly one clk regardless of tick rate.
- enabled=0:
  - IDLE does not leave IDLE.
  - Any other state aborts to IDLE on the next clk (tick not required): no pulse, data unchanged.
- States (3-bit encoding):
  - IDLE: on tick with rx_s=0, go to START with cnt=0.
  - START: each tick cnt++. On the tick where cnt==OVERSAMPLE/2-1 (mid start bit):
    - rx_s=0: go to DATA with cnt=0, bit_idx=0.
    - rx_s=1: glitch; go to IDLE with no pulse.
  - DATA: each tick cnt++. On the tick where cnt==OVERSAMPLE-1:
    - Shift right: shift <= {rx_s, shift[DATA_BITS-1:1]}.
    - cnt=0, bit_idx++.
    - If bit_idx==DATA_BITS-1, go to STOP.
  - STOP: on the tick where cnt==OVERSAMPLE-1, sample rx_s:
    - rx_s=1: data<=shift, valid=1, go to IDLE.
    - rx_s=0: frame_err=1, data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH (break/line-low recovery): stay until a tick with rx_s=1, then go to IDLE. No start is detected while in this state.
- Timing:
  - Let T0 be the tick on which IDLE first sees rx_s=0.
  - Start bit is checked at T0+OVERSAMPLE/2.
  - Data bit n is sampled at T0+OVERSAMPLE/2+OVERSAMPLE×(n+1).
  - Stop bit is sampled at T0+OVERSAMPLE/2+OVERSAMPLE×(DATA_BITS+1); with defaults this is T0+152.
  - valid is high the clk after that tick edge.
- Back-to-back frames: after a good stop sample the block is in IDLE. The next start edge can be accepted on the very next tick, since half a stop bit remains for resynchronisation.
- Counter widths: cnt is $clog2(OVERSAMPLE) bits and bit_idx is $clog2(DATA_BITS) bits. Neither counter wraps inside a state; both are explicitly cleared on state change.
- If rx_tick is held high continuously, the block runs at one sample per clk (bench mode).

Decomposition:
- Shared package uart_pkg holds:
  - RX/TX state localparams: IDLE, START, DATA, STOP, WAIT_HIGH.
  - Default OVERSAMPLE and DATA_BITS.
  - The 8N1 frame length constant.
- Sub-module uart_rx_sync: 2-FF synchroniser with reset value 1, parameterised width. It is reusable for other async inputs such as buttons.

Test Plan:
- rx_tick=1 every clk, enabled=1; drive 0xA5 (16 clk per bit, 8N1) -> data=0xA5 and valid one clk at stop sample + 1. frame_err never set. busy falls on the same clk valid rises.
- rx pulled low for 4 ticks then high -> START aborts at mid-bit check. No valid or frame_err; busy high for 8 ticks then 0. A following 0x5A frame is received correctly.
- Frame 0x3C with stop bit driven 0, rx held low 40 more ticks, then high, then frame 0x81:
  - frame_err pulses once; data stays at the previous value.
  - No start is detected while rx is low.
  - 0x81 is received with valid.
- Back-to-back 0x00 then 0xFF with exactly one stop bit between -> two valid pulses, data 0x00 then 0xFF, no frame_err.
- resetn=0 for one clk during data bit 3 of 0xC3 -> outputs return to reset values. No pulse for that frame; next 0x42 is received.
- enabled dropped during bit 5 -> IDLE next clk, no pulse. With enabled=0, a full frame 0x99 produces nothing. Re-enable, send 0x99 -> valid with data 0x99.
- Loopback: uart_tx (tx_clk = rx_tick/16) transmits 0x00..0xFF into rx -> all 256 bytes match in order, zero frame_err.
